// File: rtl/input_event_ctrl.sv
// Input event controller: synchronizes and debounces raw switch/button levels,
// latches enabled rising/falling edges as pending bits and raises a level irq.
// Latency: SYNC_STAGES + DEB_CYCLES to STATE, +1 to PEND, +1 to irq_o; bus reads 1 cycle. No backpressure.
module input_event_ctrl #(
    parameter int N_IN        = 20,
    parameter int DEB_CYCLES  = 1000000,
    parameter int SYNC_STAGES = 2
) (
    input  logic            clk_i,
    input  logic            rst_i,
    input  logic [N_IN-1:0] raw_i,
    input  logic            sel_i,
    input  logic            we_i,
    input  logic [3:0]      addr_i,
    input  logic [31:0]     wdata_i,
    output logic [31:0]     rdata_o,
    output logic            irq_o
);

    // Counter only needs to reach DEB_CYCLES-1: the DEB_CYCLES-th differing
    // cycle commits the new level instead of incrementing further.
    localparam int            CW       = (DEB_CYCLES > 1) ? $clog2(DEB_CYCLES) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(DEB_CYCLES - 1);

    logic [N_IN-1:0] r_sync [SYNC_STAGES];
    logic [CW-1:0]   r_cnt  [N_IN];
    logic [N_IN-1:0] r_state;
    logic [N_IN-1:0] r_state_d;
    logic [N_IN-1:0] r_pend;
    logic [N_IN-1:0] r_rise_en;
    logic [N_IN-1:0] r_fall_en;
    logic [31:0]     r_rdata;
    logic            r_irq;

    logic [N_IN-1:0] w_sync;
    logic [N_IN-1:0] w_set;
    logic [N_IN-1:0] w_pend_clr;
    logic            w_aligned;
    logic            w_wr;
    logic [31:0]     w_rd_word;

    assign w_sync    = r_sync[SYNC_STAGES-1];
    assign w_aligned = (addr_i[1:0] == 2'b00);
    assign w_wr      = sel_i & we_i & w_aligned;

    // Edges are taken from the debounced level against its one-cycle-old copy,
    // so PEND lands exactly one cycle after STATE moves.
    assign w_set = (r_state & ~r_state_d & r_rise_en) | (~r_state & r_state_d & r_fall_en);

    assign w_pend_clr = (w_wr && addr_i[3:2] == 2'd1) ? wdata_i[N_IN-1:0] : '0;

    // Upper write-data bits have no register behind them.
    if (N_IN < 32) begin : g_unused
        logic w_unused_wdata;
        assign w_unused_wdata = ^wdata_i[31:N_IN];
    end

    // Metastability chain on every raw input.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            for (int s = 0; s < SYNC_STAGES; s++) r_sync[s] <= '0;
        end else begin
            r_sync[0] <= raw_i;
            for (int s = 1; s < SYNC_STAGES; s++) r_sync[s] <= r_sync[s-1];
        end
    end

    // Per-input debounce: count consecutive differing cycles, commit on the last one.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            for (int i = 0; i < N_IN; i++) r_cnt[i] <= '0;
            r_state   <= '0;
            r_state_d <= '0;
        end else begin
            r_state_d <= r_state;
            for (int i = 0; i < N_IN; i++) begin
                if (w_sync[i] != r_state[i]) begin
                    if (r_cnt[i] == CNT_LAST) begin
                        r_state[i] <= w_sync[i];
                        r_cnt[i]   <= '0;
                    end else begin
                        r_cnt[i] <= r_cnt[i] + 1'b1;
                    end
                end else begin
                    r_cnt[i] <= '0;
                end
            end
        end
    end

    // Pending bits: write-1-to-clear, but a same-cycle set takes priority.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_pend <= '0;
        end else begin
            r_pend <= (r_pend & ~w_pend_clr) | w_set;
        end
    end

    // Edge enable registers; changing them never touches PEND.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_rise_en <= '0;
            r_fall_en <= '0;
        end else if (w_wr) begin
            if (addr_i[3:2] == 2'd2) r_rise_en <= wdata_i[N_IN-1:0];
            if (addr_i[3:2] == 2'd3) r_fall_en <= wdata_i[N_IN-1:0];
        end
    end

    // Read mux; unaligned offsets read as zero.
    always_comb begin
        w_rd_word = '0;
        if (w_aligned) begin
            case (addr_i[3:2])
                2'd0:    w_rd_word = 32'(r_state);
                2'd1:    w_rd_word = 32'(r_pend);
                2'd2:    w_rd_word = 32'(r_rise_en);
                default: w_rd_word = 32'(r_fall_en);
            endcase
        end
    end

    // Registered read data, held between reads.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_rdata <= '0;
        end else if (sel_i && !we_i) begin
            r_rdata <= w_rd_word;
        end
    end

    // Registered interrupt level.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_irq <= 1'b0;
        end else begin
            r_irq <= |r_pend;
        end
    end

    assign rdata_o = r_rdata;
    assign irq_o   = r_irq;

endmodule
